future_round_engine: RTL and testbench

Parametrised, self-sequenced round engine for the FUTURE-style block cipher datapath. It takes a plaintext block, two whitening/round keys and a round-constant seed. It then runs whitening, substitution, shift-row and add-round-key passes one slice per clock, under an internal FSM with a start/done handshake. The nonlinear slice function is not inside this block: it is an external shared combinational S-box/mix unit on the `sb_in`/`sb_out` port pair, so one unit can serve several engines.

---
 rtl/future_round_engine.sv | 147 ++++++++++++++
 tb/tb_future_round_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/future_round_engine.sv
// FUTURE-style round engine: one slice per clock through whitening, substitution,
// shift-row and add-round-key passes. The S-box/mix unit sits outside on sb_in_o/sb_out_i.
module future_round_engine #(
   parameter int unsigned BLOCK_W = 64,
   parameter int unsigned SLICE_W = 16,
   parameter int unsigned ROUNDS  = 10,
   parameter int unsigned KROT    = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [0:BLOCK_W-1] pt_i,
   input  logic [0:BLOCK_W-1] k0_i,
   input  logic [0:BLOCK_W-1] k1_i,
   input  logic [0:BLOCK_W-1] rc_seed_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [0:BLOCK_W-1] ct_o,
   output logic [0:SLICE_W-1] sb_in_o,
   input  logic [0:SLICE_W-1] sb_out_i,
   output logic               sb_last_o
);

   localparam int unsigned NS     = BLOCK_W / SLICE_W;
   localparam int unsigned CELL_W = SLICE_W / NS;
   localparam int unsigned SW     = $clog2(NS);
   localparam int unsigned RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [SW-1:0] SLast = SW'(NS - 1);
   localparam logic [RW-1:0] RLast = RW'(ROUNDS - 1);

   typedef enum logic [2:0] {StIdle, StWhiten, StSub, StSr, StArk} state_e;

   state_e             state_q, state_d;
   logic [0:BLOCK_W-1] x_q, x_d, k0_q, k0_d, k1_q, k1_d, rc_q, rc_d;
   logic [RW-1:0]      r_q, r_d;
   logic [SW-1:0]      s_q, s_d;
   logic               done_q, done_d;

   logic [0:BLOCK_W-1] x_sr, kx, kx_rot, rc_rot;
   logic               s_last;

   function automatic logic [0:BLOCK_W-1] rotl(input logic [0:BLOCK_W-1] v,
                                                input int unsigned n);
      int unsigned m;
      m = n % BLOCK_W;
      return (v << m) | (v >> (BLOCK_W - m));
   endfunction

   // Column-major cells: cell (c,i) at index c*NS+i; row i rotates right by i columns.
   for (genvar c = 0; c < NS; c++) begin : g_col
      for (genvar i = 0; i < NS; i++) begin : g_row
         localparam int unsigned Dst = (c * NS + i) * CELL_W;
         localparam int unsigned Src = (((c + NS - i) % NS) * NS + i) * CELL_W;
         assign x_sr[Dst +: CELL_W] = x_q[Src +: CELL_W];
      end
   end

   assign s_last = (s_q == SLast);
   assign kx     = r_q[0] ? k1_q : k0_q;
   assign kx_rot = rotl(kx, s_last ? SLICE_W + KROT : SLICE_W);
   assign rc_rot = rotl(rc_q, s_last ? 2 * SLICE_W : SLICE_W);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      k0_d    = k0_q;
      k1_d    = k1_q;
      rc_d    = rc_q;
      r_d     = r_q;
      s_d     = s_last ? '0 : SW'(s_q + 1'b1);
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            s_d = s_q;
            if (start_i) begin
               x_d     = pt_i;
               k0_d    = k0_i;
               k1_d    = k1_i;
               rc_d    = rc_seed_i;
               r_d     = '0;
               s_d     = '0;
               state_d = StWhiten;
            end
         end
         StWhiten: begin
            x_d  = {x_q[SLICE_W:BLOCK_W-1], x_q[0:SLICE_W-1] ^ k0_q[0:SLICE_W-1]};
            k0_d = rotl(k0_q, SLICE_W);
            if (s_last) state_d = StSub;
         end
         StSub: begin
            x_d = {x_q[SLICE_W:BLOCK_W-1], sb_out_i};
            if (s_last) state_d = StSr;
         end
         StSr: begin
            x_d     = x_sr;
            s_d     = '0;
            state_d = StArk;
         end
         StArk: begin
            x_d  = {x_q[SLICE_W:BLOCK_W-1],
                    x_q[0:SLICE_W-1] ^ kx[0:SLICE_W-1] ^ rc_q[0:SLICE_W-1]};
            rc_d = rc_rot;
            if (r_q[0]) k1_d = kx_rot;
            else        k0_d = kx_rot;
            if (s_last) begin
               if (r_q == RLast) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  r_d     = RW'(r_q + 1'b1);
                  state_d = StSub;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         x_q     <= '0;
         k0_q    <= '0;
         k1_q    <= '0;
         rc_q    <= '0;
         r_q     <= '0;
         s_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         k0_q    <= k0_d;
         k1_q    <= k1_d;
         rc_q    <= rc_d;
         r_q     <= r_d;
         s_q     <= s_d;
         done_q  <= done_d;
      end
   end

   assign busy_o    = (state_q != StIdle);
   assign done_o    = done_q;
   assign ct_o      = x_q;
   assign sb_in_o   = x_q[0:SLICE_W-1];
   assign sb_last_o = (state_q == StSub) && (r_q == RLast);

endmodule

// File: tb/tb_future_round_engine.sv
// Scoreboard bench for future_round_engine: stimulus queues expected ct/done edge,
// a negedge monitor pops and compares on every done pulse.
module tb_future_round_engine;

   localparam int unsigned L = 94;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [0:63] pt = '0, k0 = '0, k1 = '0, rc = '0;
   logic        busy, done, sb_last;
   logic [0:63] ct;
   logic [0:15] sb_in, sb_out;

   future_round_engine dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .pt_i      (pt),
      .k0_i      (k0),
      .k1_i      (k1),
      .rc_seed_i (rc),
      .busy_o    (busy),
      .done_o    (done),
      .ct_o      (ct),
      .sb_in_o   (sb_in),
      .sb_out_i  (sb_out),
      .sb_last_o (sb_last)
   );

   // Identity S-box stands in for the shared external unit.
   assign sb_out = sb_in;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] ct;
      int unsigned edge_n;
   } exp_t;
   exp_t        sb_q[$];
   exp_t        cur;
   int unsigned last_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
            end else begin
               cur = sb_q.pop_front();
               chk("ct", ct, cur.ct);
               chk("done_edge", 64'(cyc), 64'(cur.edge_n));
            end
         end
         if (sb_last) begin
            last_q.push_back(cyc + 1);
            chk("sb_in_slice0", 64'(sb_in), 64'(ct[0:15]));
         end
      end
   end

   // Returns at the negedge just before edge e.
   task automatic wait_edge(input int unsigned e);
      int n = 0;
      while (cyc != e - 1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (cyc != e - 1) begin
         checks++;
         errors++;
         $display("FAIL wait_edge: got cyc %0d expected %0d", cyc, e - 1);
      end
   endtask

   task automatic issue(input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] r, input logic [63:0] exp_ct,
                        output int unsigned t);
      exp_t e;
      pt    = p;
      k0    = a;
      k1    = b;
      rc    = r;
      start = 1'b1;
      t     = cyc + 1;
      e.ct     = exp_ct;
      e.edge_n = t + L;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse(input int unsigned e);
      wait_edge(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb_q.size());
         sb_q.delete();
      end
      @(negedge clk);
      chk({nm, "_busy_after"}, 64'(busy), 64'(0));
   endtask

   localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
   localparam logic [63:0] CTI  = 64'h092B4D6F81A3C5E7;
   localparam logic [63:0] ONES = '1;

   initial begin
      int unsigned t, t2;

      // Asynchronous reset between edges.
      #3 rst = 1'b1;
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_ct", ct, 64'(0));
      chk("rst_sb_in", 64'(sb_in), 64'(0));
      chk("rst_sb_last", 64'(sb_last), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      repeat (20) begin
         @(negedge clk);
         chk("idle_busy", 64'(busy), 64'(0));
         chk("idle_done", 64'(done), 64'(0));
      end

      // Identity S-box, zero keys: ct is ten shift-rows of pt.
      last_q.delete();
      issue(PT, '0, '0, '0, CTI, t);
      chk("busy_running", 64'(busy), 64'(1));
      drain("identity");
      chk("sb_last_count", 64'(last_q.size()), 64'(4));
      for (int k = 0; k < 4; k++)
         chk("sb_last_edge", (k < last_q.size()) ? 64'(last_q[k]) : '1, 64'(t + 86 + k));

      // K0 applied six times cancels; K1 five times leaves all ones.
      issue('0, ONES, '0, '0, 64'h0, t);
      drain("key0");
      issue('0, '0, ONES, '0, ONES, t);
      drain("key1");
      issue(PT, ONES, ONES, ONES, 64'hF6D4B2907E5C3A18, t);
      drain("allkeys");

      // Starts while busy (and on the final ARK edge) are ignored.
      issue(PT, '0, '0, '0, CTI, t);
      pulse(t + 1);
      wait_edge(t + 50);
      chk("busy_mid", 64'(busy), 64'(1));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulse(t + 94);
      chk("done_at_t94", 64'(done), 64'(1));
      issue('0, '0, ONES, '0, ONES, t2);
      chk("restart_edge", 64'(t2), 64'(t + 95));
      drain("handshake");

      // Abort in round 3: nothing may complete afterwards.
      issue(PT, ONES, ONES, '0, CTI, t);
      wait_edge(t + 36);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_ct", ct, 64'(0));
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (110) @(negedge clk);
      chk("abort_idle", 64'(busy), 64'(0));
      issue(PT, '0, '0, '0, CTI, t);
      drain("after_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
